// File: rtl/rijndael_key_schedule.sv
// rijndael_key_schedule: iterative Rijndael key expansion emitting NR+1 round keys over valid/ready
module rijndael_key_schedule #(
  parameter int NB = 4,
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [32*NK-1:0]  key,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [32*NB-1:0]  rk,
  output logic [3:0]        rk_index,
  output logic              rk_last,
  output logic              busy
);
  localparam int NR = (NB > NK ? NB : NK) + 6;
  localparam int STATESIZE = 32 * NB;
  localparam int KEYSIZE = 32 * NK;
  localparam int NWORDS = (NR + 1) * NB;
  localparam logic [1:0] S_IDLE = 2'd0, S_GEN = 2'd1, S_OUT = 2'd2;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  logic [1:0]           r_state;
  logic [31:0]          r_win [NK];
  logic [7:0]           r_i;
  logic [3:0]           r_kmod;
  logic [3:0]           r_bcnt;
  logic [3:0]           r_nxt;
  logic [7:0]           r_rcon;
  logic [STATESIZE-1:0] r_buf;
  logic [31:0]          w_prev, w_rot, w_sin, w_sub, w_t, w_word;
  logic                 w_full;

  assign key_ready = r_state == S_IDLE;
  assign busy      = r_state != S_IDLE;
  assign w_prev    = r_win[NK-1];
  assign w_rot     = {w_prev[23:0], w_prev[31:24]};
  assign w_sin     = r_kmod == 4'd0 ? w_rot : w_prev;
  assign w_sub     = {sbox(w_sin[31:24]), sbox(w_sin[23:16]), sbox(w_sin[15:8]), sbox(w_sin[7:0])};
  assign w_t       = r_kmod == 4'd0 ? w_sub ^ {r_rcon, 24'h0} :
                     (NK > 6 && r_kmod == 4'd4) ? w_sub : w_prev;
  assign w_word    = r_i < 8'(NK) ? r_win[0] : r_win[0] ^ w_t;
  assign w_full    = r_bcnt == 4'(NB - 1);

  // window rotates through the key words first, then slides over generated words; buffer packs NB words per round key
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      rk_valid <= 1'b0;
      rk       <= '0;
      rk_index <= '0;
      rk_last  <= 1'b0;
      r_rcon   <= 8'h01;
      r_i      <= '0;
      r_kmod   <= '0;
      r_bcnt   <= '0;
      r_nxt    <= '0;
      r_buf    <= '0;
      for (int j = 0; j < NK; j++) r_win[j] <= '0;
    end else if (r_state == S_IDLE) begin
      if (key_valid) begin
        for (int j = 0; j < NK; j++) r_win[j] <= key[KEYSIZE-1-32*j -: 32];
        r_i     <= '0;
        r_kmod  <= '0;
        r_rcon  <= 8'h01;
        r_buf   <= '0;
        r_bcnt  <= '0;
        r_nxt   <= '0;
        r_state <= S_GEN;
      end
    end else if (r_state == S_GEN) begin
      for (int j = 0; j < NK - 1; j++) r_win[j] <= r_win[j+1];
      r_win[NK-1] <= w_word;
      r_i         <= r_i < 8'(NWORDS) ? r_i + 8'd1 : r_i;
      r_kmod      <= r_kmod == 4'(NK - 1) ? 4'd0 : r_kmod + 4'd1;
      r_rcon      <= (r_i >= 8'(NK) && r_kmod == 4'd0) ? {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00) : r_rcon;
      r_buf       <= {r_buf[STATESIZE-33:0], w_word};
      r_bcnt      <= w_full ? 4'd0 : r_bcnt + 4'd1;
      if (w_full) begin
        rk       <= {r_buf[STATESIZE-33:0], w_word};
        rk_index <= r_nxt;
        rk_last  <= r_nxt == 4'(NR);
        r_nxt    <= r_nxt + 4'd1;
        rk_valid <= 1'b1;
        r_state  <= S_OUT;
      end
    end else if (rk_ready) begin
      rk_valid <= 1'b0;
      r_state  <= rk_last ? S_IDLE : S_GEN;
    end
  end
endmodule

// File: tb/tb_rijndael_key_schedule.sv
// tb_rijndael_key_schedule: checks several NB/NK builds against a FIPS-197 style software key expansion
`timescale 1ns/1ps
module tb_rijndael_key_schedule;
  function automatic int nb_of(input int c);
    return c == 3 ? 6 : (c == 4 || c == 5) ? 8 : 4;
  endfunction
  function automatic int nk_of(input int c);
    return c == 1 ? 6 : (c == 2 || c == 5) ? 8 : 4;
  endfunction

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] key_bus = '0;
  logic         kv [6];
  logic         rr [6];
  logic         kr_w [6];
  logic         rkv_w [6];
  logic         last_w [6];
  logic         busy_w [6];
  logic [3:0]   idx_w [6];
  logic [255:0] rk_w [6];
  int           n_checks = 0;
  int           n_fail = 0;
  logic [7:0]   sb [256];
  logic [31:0]  mw [240];
  logic [255:0] got [16];
  int           got_n;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 6; g++) begin : g_dut
    localparam int GNB = nb_of(g);
    localparam int GNK = nk_of(g);
    logic [32*GNB-1:0] rk_l;
    rijndael_key_schedule #(.NB(GNB), .NK(GNK)) u_dut (
      .clk(clk), .rst(rst), .key_valid(kv[g]), .key_ready(kr_w[g]),
      .key(key_bus[255 -: 32*GNK]), .rk_valid(rkv_w[g]), .rk_ready(rr[g]),
      .rk(rk_l), .rk_index(idx_w[g]), .rk_last(last_w[g]), .busy(busy_w[g]));
    assign rk_w[g] = 256'(rk_l);
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic build_model(input int nb, input int nk, input logic [255:0] keyl);
    int nr = (nb > nk ? nb : nk) + 6;
    logic [31:0] t;
    logic [7:0] rc;
    for (int i = 0; i < (nr + 1) * nb; i++) begin
      if (i < nk) mw[i] = keyl[255-32*i -: 32];
      else begin
        t = mw[i-1];
        if (i % nk == 0) begin
          rc = 8'h01;
          for (int k = 1; k < i / nk; k++) rc = gmul(rc, 8'h02);
          t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        end else if (nk > 6 && i % nk == 4) t = sub_word(t);
        mw[i] = mw[i-nk] ^ t;
      end
    end
  endtask

  function automatic logic [255:0] exp_rk(input int r, input int nb);
    logic [255:0] e = '0;
    for (int j = 0; j < nb; j++) e = (e << 32) | 256'(mw[r*nb+j]);
    return e;
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] r = '0;
    for (int k = 0; k < 8; k++) r = (r << 32) | 256'($urandom());
    return r;
  endfunction

  task automatic run_sched(input int c, input logic [255:0] keyl, input bit stall, input bit noise);
    int nb = nb_of(c);
    int nk = nk_of(c);
    int nr = (nb > nk ? nb : nk) + 6;
    int cyc = 0;
    bit done = 0, p_v = 0, p_r, first = 1;
    logic [255:0] p_rk = '0;
    logic [3:0] p_idx = '0;
    logic p_last = 1'b0;
    logic [255:0] e;
    build_model(nb, nk, keyl);
    got_n = 0;
    n_checks++;
    if (kr_w[c] !== 1'b1) begin
      n_fail++;
      $display("FAIL key_ready_at_load cfg%0d: got %b want 1", c, kr_w[c]);
    end
    key_bus = keyl;
    kv[c] = 1'b1;
    rr[c] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    p_r = rr[c];
    while (!done) begin
      @(negedge clk);
      cyc++;
      kv[c] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) key_bus = rand_key();
      if (rkv_w[c] && p_v) begin
        n_checks++;
        if (p_r || rk_w[c] !== p_rk || idx_w[c] !== p_idx || last_w[c] !== p_last) begin
          n_fail++;
          $display("FAIL hold cfg%0d cyc%0d: prev_ready=%b rk=%h idx=%0d last=%b want rk=%h idx=%0d last=%b",
                   c, cyc, p_r, rk_w[c], idx_w[c], last_w[c], p_rk, p_idx, p_last);
        end
      end else if (rkv_w[c]) begin
        if (first && !stall) begin
          n_checks++;
          if (cyc != nb + 1) begin
            n_fail++;
            $display("FAIL first_latency cfg%0d: got %0d want %0d", c, cyc, nb + 1);
          end
        end
        first = 0;
        n_checks++;
        if (got_n > nr) begin
          n_fail++;
          $display("FAIL extra_round cfg%0d: got round %0d want at most %0d", c, got_n, nr);
          done = 1;
        end else begin
          e = exp_rk(got_n, nb);
          if (rk_w[c] !== e || idx_w[c] !== 4'(got_n) || last_w[c] !== (got_n == nr)) begin
            n_fail++;
            $display("FAIL rk cfg%0d r%0d: got rk=%h idx=%0d last=%b want rk=%h idx=%0d last=%b",
                     c, got_n, rk_w[c], idx_w[c], last_w[c], e, got_n, got_n == nr);
          end
          got[got_n] = rk_w[c];
          got_n++;
        end
      end
      p_v = rkv_w[c];
      p_rk = rk_w[c];
      p_idx = idx_w[c];
      p_last = last_w[c];
      rr[c] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      p_r = rr[c];
      if (rkv_w[c] && rr[c] && last_w[c]) done = 1;
      if (cyc > 4000) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout cfg%0d: got %0d cycles want schedule end", c, cyc);
        done = 1;
      end
    end
    @(negedge clk);
    cyc++;
    kv[c] = 1'b0;
    rr[c] = 1'b1;
    n_checks++;
    if (kr_w[c] !== 1'b1 || busy_w[c] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after cfg%0d: got ready=%b busy=%b want 1 0", c, kr_w[c], busy_w[c]);
    end
    n_checks++;
    if (got_n != nr + 1) begin
      n_fail++;
      $display("FAIL round_count cfg%0d: got %0d want %0d", c, got_n, nr + 1);
    end
    if (!stall) begin
      n_checks++;
      if (cyc != (nr + 1) * (nb + 1) + 1) begin
        n_fail++;
        $display("FAIL total_cycles cfg%0d: got %0d want %0d", c, cyc - 1, (nr + 1) * (nb + 1));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (kr_w[c] !== 1'b1 || busy_w[c] !== 1'b0 || rkv_w[c] !== 1'b0 || rk_w[c] !== '0 ||
          idx_w[c] !== 4'd0 || last_w[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cfg%0d: got ready=%b busy=%b valid=%b rk=%h idx=%0d last=%b want 1 0 0 0 0 0",
                 c, kr_w[c], busy_w[c], rkv_w[c], rk_w[c], idx_w[c], last_w[c]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_aes128();
    run_sched(0, K128, 0, 0);
    n_checks++;
    if (got[0] !== 256'h2b7e151628aed2a6abf7158809cf4f3c) begin
      n_fail++;
      $display("FAIL aes128_rk0: got %h want 2b7e151628aed2a6abf7158809cf4f3c", got[0]);
    end
    n_checks++;
    if (got[1] !== 256'ha0fafe1788542cb123a339392a6c7605) begin
      n_fail++;
      $display("FAIL aes128_rk1: got %h want a0fafe1788542cb123a339392a6c7605", got[1]);
    end
    n_checks++;
    if (got[10] !== 256'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_fail++;
      $display("FAIL aes128_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got[10]);
    end
  endtask

  task automatic test_aes192();
    run_sched(1, K192, 0, 0);
    n_checks++;
    if (got[1] !== 256'h62f8ead2522c6b7bfe0c91f72402f5a5) begin
      n_fail++;
      $display("FAIL aes192_rk1: got %h want 62f8ead2522c6b7bfe0c91f72402f5a5", got[1]);
    end
  endtask

  task automatic test_aes256();
    run_sched(2, K256, 0, 0);
    n_checks++;
    if (got[14] !== 256'h24fc79ccbf0979e9371ac23c6d68de36) begin
      n_fail++;
      $display("FAIL aes256_rk14: got %h want 24fc79ccbf0979e9371ac23c6d68de36", got[14]);
    end
  endtask

  task automatic test_back_pressure();
    run_sched(0, K128, 1, 1);
    n_checks++;
    if (got[10] !== 256'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_fail++;
      $display("FAIL stalled_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got[10]);
    end
    run_sched(5, rand_key(), 1, 1);
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    bit seen = 0;
    key_bus = rand_key();
    kv[0] = 1'b1;
    rr[0] = 1'b1;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      kv[0] = 1'b0;
      seen = rkv_w[0] && idx_w[0] == 4'd5;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL reach_round5: got no round 5 in %0d cycles want it", cyc);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (kr_w[0] !== 1'b1 || rkv_w[0] !== 1'b0 || idx_w[0] !== 4'd0 || busy_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got ready=%b valid=%b idx=%0d busy=%b want 1 0 0 0",
               kr_w[0], rkv_w[0], idx_w[0], busy_w[0]);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | rkv_w[0];
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL valid_after_reset: got rk_valid=1 want 0");
    end
    run_sched(0, K128, 0, 0);
    n_checks++;
    if (got[1] !== 256'ha0fafe1788542cb123a339392a6c7605) begin
      n_fail++;
      $display("FAIL rk1_after_reset: got %h want a0fafe1788542cb123a339392a6c7605", got[1]);
    end
  endtask

  task automatic test_rijndael();
    run_sched(3, rand_key(), 0, 0);
    run_sched(4, rand_key(), 0, 0);
    run_sched(5, rand_key(), 0, 0);
    run_sched(4, rand_key(), 1, 0);
  endtask

  task automatic test_back_to_back();
    run_sched(0, rand_key(), 0, 0);
    run_sched(0, rand_key(), 0, 0);
    run_sched(3, rand_key(), 0, 0);
    run_sched(3, rand_key(), 1, 0);
  endtask

  initial begin
    for (int k = 0; k < 6; k++) begin
      kv[k] = 1'b0;
      rr[k] = 1'b1;
    end
    init_sbox();
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_back_pressure();
    test_reset_mid();
    test_rijndael();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rijndael_key_schedule.md
# rijndael_key_schedule

Iterative Rijndael key-expansion engine. It accepts a cipher key of NK words and emits the NR+1 round keys of NB words each, one at a time, over a valid/ready stream. It sits beside the round datapath, directly downstream of the mix-columns stage. Each emitted round key is XORed by add-round-key into the mix-columns output. Word generation is one 32-bit word per cycle, so the whole block uses a single S-box row of four bytes.

## Interface
- NB, default 4: state width in 32-bit words; legal 4..8.
- NK, default 4: key length in 32-bit words; legal 4..8.
- Localparams:
  - NR = max(NB,NK)+6.
  - STATESIZE = 32*NB.
  - KEYSIZE = 32*NK.
  - NWORDS = (NR+1)*NB.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset; overrides every other input.
- key_valid  in  1  a cipher key is presented.
- key_ready  out  1  block is idle and accepts a key.
- key  in  KEYSIZE  cipher key; w[0] = key[KEYSIZE-1 -: 32]; byte 0 of each word is in its MSBs.
- rk_valid  out  1  round key on rk is valid.
- rk_ready  in  1  consumer accepts rk.
- rk  out  STATESIZE  round key; w[r*NB] is in the MSBs, same byte mapping as the state bus.
- rk_index  out  4  round number r of rk, 0..NR.
- rk_last  out  1  high with rk_valid when rk_index == NR.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, GEN, OUT.
- IDLE:
  - key_ready = 1.
  - On key_valid & key_ready: capture key into an NK-word sliding window, set word counter i = 0, set rcon = 8'h01, clear the assembly buffer, go to GEN.
- GEN: each cycle produces word w[i] and shifts it into the NB-word assembly buffer.
  - For i < NK: w[i] is key word i, taken from the captured window.
  - For i >= NK: w[i] = w[i-NK] ^ t, where t is selected as follows.
    - i mod NK == 0: t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}. After this use, rcon <= xtime(rcon), with reduction polynomial 8'h1b.
    - NK > 6 and i mod NK == 4: t = SubWord(w[i-1]).
    - Otherwise: t = w[i-1].
  - The window shifts by one word per generated word once i >= NK.
  - When the buffer holds NB words, load rk and rk_index and go to OUT.
- OUT:
  - rk_valid = 1. rk, rk_index and rk_last are held stable until rk_ready.
  - On rk_valid & rk_ready: go to IDLE if rk_index == NR, else go to GEN.
- SubWord is the standard AES S-box applied to each of the 4 bytes. RotWord rotates the word left by one byte.
- key_valid is ignored outside IDLE; a new key cannot abort a schedule in progress.
- i counts 0..NWORDS-1 and never wraps within one schedule.
- rk_index counts 0..NR, then resets to 0 on the next key load.

## Timing
- Reset values:
  - State = IDLE, so key_ready = 1 and busy = 0.
  - rk_valid = 0, rk = 0, rk_index = 0, rk_last = 0.
  - rcon = 8'h01, i = 0.
- rst asserted in GEN or OUT: the next cycle is IDLE with all reset values. Any partially assembled round key is discarded and no rk_valid pulse follows.
- key_ready and busy are decoded from the state register. rk_valid is registered.
- Latency: with the key handshake at edge E, rk_valid is first high after edge E+NB (round 0).
- Each further round key needs NB GEN cycles plus at least one OUT cycle. With rk_ready held at 1 the period is NB+1 cycles.
- Total schedule with rk_ready held at 1: (NR+1)*(NB+1) cycles from the key handshake to the return to IDLE. Example: NB=NK=4 gives 55.
- Back-pressure: rk_ready low in OUT stalls the block indefinitely with all outputs stable. Nothing advances.
- A key can be accepted in the first IDLE cycle after the last OUT handshake. There is no dead cycle beyond that.
- No combinational path from key_valid or rk_ready to any output.

## Test plan
- AES-128 (NB=4, NK=4), key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1:
  - Exactly 11 round keys.
  - rk0 = the key; rk1 = a0fafe1788542cb123a339392a6c7605; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last = 1.
  - Back in IDLE 55 cycles after the handshake.
- AES-192 (NB=4, NK=6), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk1 = 62f8ead2522c6b7bfe0c91f72402f5a5; 13 round keys in total.
- AES-256 (NB=4, NK=8), key 000102…1f -> rk14 = 24fc79ccbf0979e9371ac23c6d68de36. This exercises the i mod NK == 4 SubWord path.
- Back-pressure:
  - Randomly toggle rk_ready on AES-128 -> the rk sequence is identical to the unstalled run.
  - rk, rk_index and rk_last stay stable while rk_valid & !rk_ready.
  - key_valid pulses during the schedule are ignored.
- Reset mid-schedule: assert rst for one cycle while rk_index = 5.
  - Next cycle: key_ready = 1, rk_valid = 0, rk_index = 0.
  - A fresh AES-128 key then gives a correct rk0 and rk1, confirming rcon was restarted at 01.
- Rijndael NB=6 and NB=8 at NK=4 and NK=8: compare every round key against the golden software model.
  - Round-key counts are 13 (NB=6), 15 (NB=8) and 15 (NK=8).
  - Cross-round-boundary word packing is correct.
